// File: rtl/bram_frame_ctrl_pkg.sv
// Shared types and defaults for the input-BRAM frame controller.
// No logic; compile before the interface and the controller.
// Consumers import bram_ctrl_pkg::*.
package bram_ctrl_pkg;

    typedef enum logic {LOAD, READY} frame_state_t;

    localparam int DEFAULT_FRAME_LEN = 784;
    localparam int BRAM_ADDR_W       = 16;
    localparam int BRAM_DATA_W       = 8;

endpackage

// File: rtl/bram_frame_ctrl_if.sv
// Stream-in and random-read handshake bundle for the frame controller.
// master = stream source / layer engine side, slave = controller side.
// Widths follow the BRAM geometry.
interface bram_frame_ctrl_if
    import bram_ctrl_pkg::*;
#(
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_done;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output s_valid, s_data, rd_req, rd_addr, rd_done,
        input  s_ready, rd_valid, rd_data
    );

    modport slave (
        input  s_valid, s_data, rd_req, rd_addr, rd_done,
        output s_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/bram_frame_ctrl.sv
// Loads one frame from a byte stream into the input BRAM, then serves reads to the layer engine.
// Latency: stream byte written same cycle; read data valid exactly 1 cycle after rd_req.
// Backpressure: s_ready low while a frame is held (READY); reads are never stalled.
module bram_frame_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = BRAM_ADDR_W,
    parameter int DATA_W    = BRAM_DATA_W,
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN
)(
    input  logic               clk,
    input  logic               rst_n,
    bram_frame_ctrl_if.slave   bus,
    output logic               frame_ready,
    output logic               rd_err,
    output logic [7:0]         frame_count,
    output logic               bram_we,
    output logic [DATA_W-1:0]  bram_din,
    output logic [ADDR_W-1:0]  bram_addr,
    input  logic [DATA_W-1:0]  bram_dout
);

    // wr_ptr carries one extra bit so a full 2^ADDR_W frame needs no special case
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(FRAME_LEN - 1);
    localparam logic [ADDR_W:0] LEN_EXT  = (ADDR_W+1)'(FRAME_LEN);

    frame_state_t      state, next_state;
    logic [ADDR_W:0]   wr_ptr;
    logic              rd_oob;
    logic              rd_accept;
    logic              req_oob;
    logic              last_wr;

    assign rd_accept = (state == READY) && bus.rd_req;
    assign req_oob   = {1'b0, bus.rd_addr} >= LEN_EXT;
    assign last_wr   = (wr_ptr == LAST_IDX);

    // Out-of-range reads return zero instead of whatever the BRAM holds there
    assign bus.rd_data = rd_oob ? '0 : bram_dout;

    // Next state, handshake decode and BRAM port steering
    always_comb begin
        next_state      = state;
        bus.s_ready     = 1'b0;
        frame_ready     = 1'b0;
        bram_we         = 1'b0;
        bram_din        = '0;
        bram_addr       = bus.rd_addr;
        case (state)
            LOAD: begin
                bus.s_ready = 1'b1;
                bram_we     = bus.s_valid;
                bram_din    = bus.s_data;
                bram_addr   = wr_ptr[ADDR_W-1:0];
                if (bus.s_valid && last_wr)
                    next_state = READY;
            end
            READY: begin
                frame_ready = 1'b1;
                if (bus.rd_done)
                    next_state = LOAD;
            end
            default: next_state = LOAD;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= next_state;
    end

    // Write pointer and completed-frame counter advance on accepted stream bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            frame_count <= '0;
        end else if (state == LOAD && bus.s_valid) begin
            if (last_wr) begin
                wr_ptr      <= '0;
                frame_count <= frame_count + 8'd1;
            end else begin
                wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
            end
        end
    end

    // Read-valid pipeline stage aligned with the registered BRAM output, plus sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_valid <= 1'b0;
            rd_oob       <= 1'b0;
            rd_err       <= 1'b0;
        end else begin
            bus.rd_valid <= rd_accept;
            rd_oob       <= rd_accept && req_oob;
            if (rd_accept && req_oob)
                rd_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bram_frame_ctrl.sv
// Bench for bram_frame_ctrl with FRAME_LEN=4 and a behavioural BRAM beside it.
// Reference model: expected frame bytes, frame counter and sticky error flag.
// Inputs driven on the falling edge, outputs sampled on the falling edge or 1ns after driving.
module tb_bram_frame_ctrl;
    import bram_ctrl_pkg::*;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;
    localparam int FRAME_LEN = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_frame_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic              frame_ready;
    logic              rd_err;
    logic [7:0]        frame_count;
    logic              bram_we;
    logic [DATA_W-1:0] bram_din;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;

    bram_frame_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .frame_ready(frame_ready), .rd_err(rd_err), .frame_count(frame_count),
        .bram_we(bram_we), .bram_din(bram_din), .bram_addr(bram_addr), .bram_dout(bram_dout)
    );

    // Behavioural single-port BRAM with registered read
    logic [DATA_W-1:0] bram_mem [0:65535];
    always @(posedge clk) begin
        if (bram_we) bram_mem[bram_addr] <= bram_din;
        bram_dout <= bram_mem[bram_addr];
    end

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] exp_mem [FRAME_LEN];
    int exp_fc = 0;
    bit exp_err = 1'b0;

    task automatic drive_idle();
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;
        bus.rd_done = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        #3;
        checks++;
        if (bus.s_ready !== 1'b1 || frame_ready !== 1'b0 || bram_we !== 1'b0 ||
            bus.rd_valid !== 1'b0 || rd_err !== 1'b0 || frame_count !== 8'd0)
            begin failures++; $display("FAIL reset_state: s_ready=%b frame_ready=%b we=%b rd_valid=%b rd_err=%b fc=%0d required 1 0 0 0 0 0",
                bus.s_ready, frame_ready, bram_we, bus.rd_valid, rd_err, frame_count); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_fc = 0;
        exp_err = 1'b0;
    endtask

    // Stream one frame; optional idle gaps and ignored read traffic while loading
    task automatic load_frame(input logic [FRAME_LEN*DATA_W-1:0] data, input bit gaps, input bit rd_noise);
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    @(negedge clk);
                    drive_idle();
                    #1;
                    checks++;
                    if (bram_we !== 1'b0 || frame_ready !== 1'b0)
                        begin failures++; $display("FAIL load_gap: we=%b frame_ready=%b required 0 0", bram_we, frame_ready); end
                end
            end
            @(negedge clk);
            if (rd_noise && i > 0) begin
                checks++;
                if (bus.rd_valid !== 1'b0 || rd_err !== exp_err)
                    begin failures++; $display("FAIL load_ignores_reads: rd_valid=%b rd_err=%b required 0 %b", bus.rd_valid, rd_err, exp_err); end
            end
            bus.s_valid = 1'b1;
            bus.s_data  = data[i*DATA_W +: DATA_W];
            bus.rd_req  = rd_noise;
            bus.rd_addr = rd_noise ? ADDR_W'($urandom_range(0, 7)) : '0;
            bus.rd_done = rd_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            checks++;
            if (bram_we !== 1'b1 || bram_addr !== ADDR_W'(i) || bram_din !== data[i*DATA_W +: DATA_W] ||
                bus.s_ready !== 1'b1 || frame_ready !== 1'b0)
                begin failures++; $display("FAIL load_write%0d: we=%b addr=%0d din=%h s_ready=%b frame_ready=%b required 1 %0d %h 1 0",
                    i, bram_we, bram_addr, bram_din, bus.s_ready, frame_ready, i, data[i*DATA_W +: DATA_W]); end
            exp_mem[i] = data[i*DATA_W +: DATA_W];
        end
        @(negedge clk);
        drive_idle();
        exp_fc++;
        #1;
        checks++;
        if (frame_ready !== 1'b1 || bus.s_ready !== 1'b0 || frame_count !== 8'(exp_fc) || rd_err !== exp_err)
            begin failures++; $display("FAIL load_complete: frame_ready=%b s_ready=%b fc=%0d rd_err=%b required 1 0 %0d %b",
                frame_ready, bus.s_ready, frame_count, rd_err, 8'(exp_fc), exp_err); end
    endtask

    // Issue reads (fixed list if given, else n random ones) and check each one cycle later
    task automatic test_reads(input int n, input int max_addr, input int fixed[$]);
        bit pend_v = 1'b0;
        int pend_a = 0;
        int total;
        logic [DATA_W-1:0] want;
        total = (fixed.size() > 0) ? fixed.size() : n;
        for (int k = 0; k <= total; k++) begin
            @(negedge clk);
            if (pend_v && pend_a >= FRAME_LEN) exp_err = 1'b1;
            want = (pend_a >= FRAME_LEN) ? '0 : exp_mem[pend_a];
            checks++;
            if (bus.rd_valid !== pend_v || (pend_v && bus.rd_data !== want) ||
                rd_err !== exp_err || frame_ready !== 1'b1)
                begin failures++; $display("FAIL read_addr%0d: rd_valid=%b rd_data=%h rd_err=%b frame_ready=%b required %b %h %b 1",
                    pend_a, bus.rd_valid, bus.rd_data, rd_err, frame_ready, pend_v, want, exp_err); end
            drive_idle();
            pend_v = 1'b0;
            if (k < total) begin
                if (fixed.size() > 0) begin
                    pend_v = 1'b1;
                    pend_a = fixed[k];
                end else begin
                    pend_v = ($urandom_range(0, 3) != 0);
                    pend_a = $urandom_range(0, max_addr);
                end
                bus.rd_req  = pend_v;
                bus.rd_addr = ADDR_W'(pend_a);
                #1;
                checks++;
                if (bram_we !== 1'b0 || bram_addr !== ADDR_W'(pend_a))
                    begin failures++; $display("FAIL read_bram_drive: we=%b addr=%0d required 0 %0d", bram_we, bram_addr, pend_a); end
            end
        end
        drive_idle();
    endtask

    // Release frame with a read in the same cycle, then reload
    task automatic test_done_with_read();
        @(negedge clk);
        bus.rd_done = 1'b1;
        bus.rd_req  = 1'b1;
        bus.rd_addr = ADDR_W'(1);
        @(negedge clk);
        drive_idle();
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_mem[1] || frame_ready !== 1'b0 || bus.s_ready !== 1'b1)
            begin failures++; $display("FAIL done_with_read: rd_valid=%b rd_data=%h frame_ready=%b s_ready=%b required 1 %h 0 1",
                bus.rd_valid, bus.rd_data, frame_ready, bus.s_ready, exp_mem[1]); end
        load_frame({8'hA3, 8'hA2, 8'hA1, 8'hA0}, 1'b0, 1'b1);
    endtask

    // Stream source keeps pushing while the frame is held
    task automatic test_hold_svalid();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = 8'($urandom);
            #1;
            checks++;
            if (bram_we !== 1'b0 || bus.s_ready !== 1'b0 || frame_ready !== 1'b1)
                begin failures++; $display("FAIL hold_svalid: we=%b s_ready=%b frame_ready=%b required 0 0 1", bram_we, bus.s_ready, frame_ready); end
        end
        drive_idle();
    endtask

    // Plain release without a read: s_ready rises the following cycle
    task automatic release_frame();
        @(negedge clk);
        bus.rd_done = 1'b1;
        #1;
        checks++;
        if (bus.s_ready !== 1'b0)
            begin failures++; $display("FAIL release_same_cycle: s_ready=%b required 0", bus.s_ready); end
        @(negedge clk);
        drive_idle();
        checks++;
        if (bus.s_ready !== 1'b1 || frame_ready !== 1'b0 || bus.rd_valid !== 1'b0)
            begin failures++; $display("FAIL release_next_cycle: s_ready=%b frame_ready=%b rd_valid=%b required 1 0 0",
                bus.s_ready, frame_ready, bus.rd_valid); end
    endtask

    task automatic test_midload_reset();
        int q[$];
        release_frame();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = 8'hE0 + 8'(i);
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.s_ready !== 1'b1 || frame_ready !== 1'b0 || bus.rd_valid !== 1'b0 ||
            rd_err !== 1'b0 || frame_count !== 8'd0 || bram_we !== 1'b0)
            begin failures++; $display("FAIL midload_reset: s_ready=%b frame_ready=%b rd_valid=%b rd_err=%b fc=%0d we=%b required 1 0 0 0 0 0",
                bus.s_ready, frame_ready, bus.rd_valid, rd_err, frame_count, bram_we); end
        exp_fc = 0;
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        load_frame({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 1'b0, 1'b0);
        q = {0, 1, 2, 3};
        test_reads(0, 0, q);
    endtask

    task automatic test_count_wrap();
        for (int f = 0; f < 255; f++) begin
            release_frame();
            load_frame({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int q[$];
        int empty_q[$];
        test_reset();
        // Plan item 1: known bytes, no gaps
        load_frame({8'h44, 8'h33, 8'h22, 8'h11}, 1'b0, 1'b0);
        // Plan item 2: fixed reads
        q = {2, 0, 3};
        test_reads(0, 0, q);
        // Plan item 3: out-of-range then in-range reads
        q = {4, 1, 2};
        test_reads(0, 0, q);
        // Random reads incl. out of range
        test_reads(40, 7, empty_q);
        test_done_with_read();
        test_reads(30, 5, empty_q);
        // Gapped reload with random data, then held s_valid in READY
        release_frame();
        load_frame({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 1'b1, 1'b0);
        test_hold_svalid();
        test_reads(30, 5, empty_q);
        test_midload_reset();
        test_count_wrap();
        test_reads(20, 5, empty_q);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_frame_ctrl.md
Name: bram_frame_ctrl

Overview:
- Sequences the shared 64K x 8 input BRAM: first loads one input frame from a byte stream into addresses 0..FRAME_LEN-1.
- Then serves random-access reads to the first network layer until that layer releases the frame.
- Sits between the input stream source, the BRAM instance (`bram_storage`) and the layer engine.
- Drives every BRAM port; the BRAM is instantiated beside this block at the input-module top.

Parameters:
- ADDR_W, 16, BRAM address width.
- DATA_W, 8, BRAM/stream data width.
- FRAME_LEN, 784, bytes per frame (28x28). Legal range 1..2^ADDR_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  stream byte valid
- s_data  in  DATA_W  stream byte
- s_ready  out  1  stream accept
- rd_req  in  1  read request (one per cycle allowed)
- rd_addr  in  ADDR_W  read address
- rd_done  in  1  consumer releases frame (1-cycle pulse)
- rd_valid  out  1  read data valid
- rd_data  out  DATA_W  read data
- frame_ready  out  1  frame loaded, reads served
- rd_err  out  1  sticky out-of-range read flag
- frame_count  out  8  frames completed, wraps at 255->0
- bram_we  out  1  to BRAM write_enable
- bram_din  out  DATA_W  to BRAM data_in
- bram_addr  out  ADDR_W  to BRAM addr
- bram_dout  in  DATA_W  from BRAM data_out (registered, 1-cycle)

Behaviour:

Reset (async assert, sync release):
- state=LOAD, wr_ptr=0, rd_valid=0, rd_err=0, frame_count=0, rd_oob=0.
- Outputs during reset: s_ready=1, frame_ready=0, bram_we=0.
- BRAM contents are not cleared.
- Reset mid-load discards the partial frame; the next load restarts at address 0.

States:
- LOAD: s_ready=1, frame_ready=0.
- READY: s_ready=0, frame_ready=1.
- s_ready and frame_ready decode combinationally from the state register.

BRAM drive (combinational from state and inputs):
- LOAD: bram_addr=wr_ptr, bram_din=s_data, bram_we=s_valid.
- READY: bram_addr=rd_addr, bram_we=0, bram_din=0.

LOAD:
- Each cycle with s_valid=1 writes s_data at wr_ptr and increments wr_ptr.
- When a write is accepted with wr_ptr==FRAME_LEN-1:
  - wr_ptr <= 0, state <= READY, frame_count <= frame_count+1.
  - frame_ready=1 from the next cycle.
- rd_req and rd_done are ignored in LOAD: no rd_valid, no rd_err.

READY:
- rd_req sampled high at edge N gives rd_valid=1 in cycle N+1 with rd_data = BRAM word at rd_addr. Latency exactly 1; back-to-back requests give back-to-back rd_valid.
- rd_data = bram_dout when rd_oob=0, else 0.
- Out of range means rd_addr >= FRAME_LEN. Such a request:
  - still produces rd_valid, with rd_data forced to 0;
  - sets rd_err, which stays set until reset.
- The rd_oob register captures the range check alongside rd_valid.
- rd_done in READY: state <= LOAD at that edge.
  - An rd_req in the same cycle is still served; its rd_valid appears in the first LOAD cycle.
  - s_ready rises in the cycle after rd_done.
- s_valid in READY is not accepted (s_ready=0); the source holds data.

Widths and counters:
- wr_ptr is ADDR_W+1 bits, so FRAME_LEN=2^ADDR_W needs no special case.
- frame_count wraps modulo 256.
- rd_valid is 0 whenever no read was accepted the previous cycle.

Decomposition:
- Package bram_ctrl_pkg holds:
  - typedef enum logic {LOAD, READY} frame_state_t;
  - localparams DEFAULT_FRAME_LEN=784, BRAM_ADDR_W=16, BRAM_DATA_W=8.
- No sub-module: single FSM plus pointer plus read-valid pipeline register.
- bram_storage is not instantiated inside this block.

Test Plan:
1. FRAME_LEN=4, reset, stream 0x11,0x22,0x33,0x44 on consecutive cycles:
   - bram_addr 0..3 with bram_we=1;
   - frame_ready=1 the cycle after the 4th byte; frame_count=1; s_ready=0.
2. Continuing 1, rd_req on addrs 2,0,3 in consecutive cycles:
   - rd_valid high for 3 cycles starting one cycle later;
   - rd_data 0x33, 0x11, 0x44; rd_err=0.
3. READY, rd_req addr 4 (FRAME_LEN=4):
   - next cycle rd_valid=1, rd_data=0x00, rd_err=1;
   - rd_err stays 1 after further valid reads.
4. rd_done and rd_req(addr 1) in the same cycle:
   - next cycle rd_valid=1, rd_data=0x22, frame_ready=0, s_ready=1;
   - stream 0xA0..0xA3 reloads; frame_count=2.
5. s_valid gapped (1,0,1,1,0,1) in LOAD: exactly 4 writes at addrs 0..3, FSM enters READY only after the 4th accepted byte. s_valid held high in READY: no bram_we.
6. Assert rst_n=0 after 2 bytes of a load:
   - outputs return to reset values immediately (asynchronously);
   - after release a fresh 4-byte frame writes addrs 0..3; frame_count=1.
